// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: default datapath width, the NOP used to fill bubbles,
// and the {pc, instr} entry shared with the decode and redirect logic.
package fetch_pkg;

   localparam int XLEN_DEFAULT = 32;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [XLEN_DEFAULT-1:0] instr;
   } fetch_entry_t;

   function automatic fetch_entry_t make_entry(input logic [XLEN_DEFAULT-1:0] pc,
                                               input logic [XLEN_DEFAULT-1:0] instr);
      fetch_entry_t e;
      e.pc    = pc;
      e.instr = instr;
      return e;
   endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH x 2*XLEN register array holding {pc, instr} pairs: synchronous write,
// asynchronous read, cleared by the asynchronous reset.
module fetch_queue_mem #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [2*XLEN-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [2*XLEN-1:0] rd_data
);

   logic [2*XLEN-1:0] mem_reg [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (wr_en) begin
         mem_reg[wr_addr] <= wr_data;
      end
   end

   // Read is combinational so a freshly written head is visible right after its write edge.
   assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode FIFO of {pc, instr} pairs with valid/ready on both sides,
// single-cycle flush for branch redirect and occupancy reporting.
module fetch_queue
   import fetch_pkg::XLEN_DEFAULT;
#(
   parameter int              XLEN      = XLEN_DEFAULT,
   parameter int              DEPTH     = 4,
   parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(fetch_pkg::NOP_INSTR)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          in_pc,
   input  logic [XLEN-1:0]          in_instr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_pc,
   output logic [XLEN-1:0]          out_instr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]       rd_ptr_reg, rd_ptr_next;
   logic [AW:0]       wr_ptr_reg, wr_ptr_next;
   logic              empty, full, push, pop;
   logic [2*XLEN-1:0] rd_data;

   assign empty = (rd_ptr_reg == wr_ptr_reg);
   assign full  = (rd_ptr_reg[AW-1:0] == wr_ptr_reg[AW-1:0]) && (rd_ptr_reg[AW] != wr_ptr_reg[AW]);

   assign in_ready  = ~full;
   assign out_valid = ~empty;
   assign push      = in_valid & ~full & ~flush;
   assign pop       = ~empty & out_ready & ~flush;

   always_comb begin
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      if (flush) begin
         rd_ptr_next = '0;
         wr_ptr_next = '0;
      end else begin
         if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
      end else begin
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
      end
   end

   // Modulo-2*DEPTH pointer difference is exactly the occupancy 0..DEPTH.
   assign count = wr_ptr_reg - rd_ptr_reg;

   fetch_queue_mem #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_addr (wr_ptr_reg[AW-1:0]),
      .wr_data ({in_pc, in_instr}),
      .rd_addr (rd_ptr_reg[AW-1:0]),
      .rd_data (rd_data)
   );

   assign out_pc    = empty ? '0 : rd_data[2*XLEN-1:XLEN];
   assign out_instr = empty ? NOP_INSTR : rd_data[XLEN-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model compared every cycle,
// plus directed checks with hand-computed values for each scenario.
module tb_fetch_queue;
   import fetch_pkg::*;

   localparam int DEPTH = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0;
   logic [31:0] in_instr = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [2:0]  count;

   int tests = 0;
   int fails = 0;

   fetch_entry_t model_q[$];

   always #5 clk = ~clk;

   fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .count     (count)
   );

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return pc ^ 32'hDEAD_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: a plain FIFO of entries, updated from the handshake rules.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_q.delete();
      end else if (flush) begin
         model_q.delete();
      end else begin
         automatic bit do_push = in_valid && (model_q.size() < DEPTH);
         automatic bit do_pop  = out_ready && (model_q.size() > 0);
         if (do_pop) void'(model_q.pop_front());
         if (do_push) model_q.push_back(make_entry(in_pc, in_instr));
      end
   end

   always @(negedge clk) begin
      automatic int n = model_q.size();
      check("out_valid", {31'b0, out_valid}, {31'b0, n != 0});
      check("in_ready", {31'b0, in_ready}, {31'b0, n != DEPTH});
      check("count", {29'b0, count}, n);
      check("out_pc", out_pc, (n != 0) ? model_q[0].pc : 32'h0);
      check("out_instr", out_instr, (n != 0) ? model_q[0].instr : NOP);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
      in_valid  = v;
      in_pc     = pc;
      in_instr  = instr_of(pc);
      out_ready = ordy;
      flush     = fl;
   endtask

   initial begin
      // 1: reset mid-cycle, checked before any clock edge
      #2 rst = 1'b1;
      #1;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_count", {29'b0, count}, 32'd0);
      check("rst_out_instr", out_instr, 32'h0000_0013);
      check("rst_out_pc", out_pc, 32'h0);
      $display("[TB] reset: out_valid=%0b in_ready=%0b count=%0d", out_valid, in_ready, count);
      @(posedge clk);
      #3 rst = 1'b0;

      // 2: fill then drain
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
         step();
         $display("[TB] push pc=%h count=%0d", 32'(i * 4), count);
      end
      check("fill_count", {29'b0, count}, 32'd4);
      check("fill_in_ready", {31'b0, in_ready}, 32'd0);
      drive(1'b1, 32'h10, 1'b0, 1'b0);
      step();
      check("fifth_push_count", {29'b0, count}, 32'd4);
      check("fifth_push_head", out_pc, 32'h0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0);
         check("drain_pc", out_pc, 32'(i * 4));
         $display("[TB] pop pc=%h", out_pc);
         step();
      end
      check("drained_valid", {31'b0, out_valid}, 32'd0);

      // 3: streaming, one-cycle latency with occupancy held at 1
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 32'h100 + 32'(i * 4), 1'b1, 1'b0);
         if (i > 0) begin
            check("stream_pc", out_pc, 32'h100 + 32'((i - 1) * 4));
            check("stream_count", {29'b0, count}, 32'd1);
         end
         step();
      end
      check("stream_last", out_pc, 32'h14C);
      $display("[TB] stream done head=%h count=%0d", out_pc, count);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      check("stream_empty", {31'b0, out_valid}, 32'd0);

      // 4: full with simultaneous push and pop
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b0);
         step();
      end
      check("full_count", {29'b0, count}, 32'd4);
      drive(1'b1, 32'h510, 1'b1, 1'b0);
      step();
      check("full_pushpop_count", {29'b0, count}, 32'd3);
      check("full_pushpop_head", out_pc, 32'h504);
      drive(1'b1, 32'h510, 1'b0, 1'b0);
      step();
      check("refill_count", {29'b0, count}, 32'd4);
      $display("[TB] full push/pop head=%h count=%0d", out_pc, count);

      // 5: flush with pending traffic
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      check("preflush_count", {29'b0, count}, 32'd3);
      check("preflush_head", out_pc, 32'h508);
      drive(1'b1, 32'h200, 1'b1, 1'b1);
      step();
      check("flush_count", {29'b0, count}, 32'd0);
      check("flush_valid", {31'b0, out_valid}, 32'd0);
      check("flush_instr", out_instr, 32'h0000_0013);
      drive(1'b1, 32'h300, 1'b0, 1'b0);
      step();
      check("postflush_head", out_pc, 32'h300);
      check("postflush_count", {29'b0, count}, 32'd1);
      $display("[TB] flush then push head=%h", out_pc);

      // 6: reset mid-operation
      drive(1'b1, 32'h304, 1'b0, 1'b0);
      step();
      check("prerst_count", {29'b0, count}, 32'd2);
      drive(1'b1, 32'h308, 1'b0, 1'b0);
      #3 rst = 1'b1;
      #1;
      check("midrst_valid", {31'b0, out_valid}, 32'd0);
      check("midrst_count", {29'b0, count}, 32'd0);
      check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      check("midrst_pc", out_pc, 32'h0);
      check("midrst_instr", out_instr, 32'h0000_0013);
      drive(1'b1, 32'h40, 1'b0, 1'b0);
      @(posedge clk);
      #3 rst = 1'b0;
      step();
      check("postrst_head", out_pc, 32'h40);
      check("postrst_instr", out_instr, 32'hDEAD_0040);
      check("postrst_count", {29'b0, count}, 32'd1);
      $display("[TB] after reset head=%h count=%0d", out_pc, count);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-entry fetch/decode pipeline latch.
- A DEPTH-entry FIFO of {pc, instr} pairs sitting between the instruction fetch stage and decode.
- Uses a valid/ready handshake on both sides and supports a single-cycle flush for branch redirect.
- Adds backpressure and occupancy reporting, and decouples fetch from decode stalls.

Parameters:
- XLEN, 32: width of the pc and instr fields.
- DEPTH, 4: number of entries. Must be a power of 2 and at least 2.
- NOP_INSTR, 32'h0000_0013: value driven on out_instr while the queue is empty (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all entries (redirect); takes priority over push and pop.
- in_valid  in  1  fetch presents a valid {in_pc, in_instr}.
- in_ready  out  1  queue can accept an entry this cycle.
- in_pc  in  XLEN  pc of the fetched instruction.
- in_instr  in  XLEN  fetched instruction word.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode consumes the head this cycle (replaces the old hold signal, inverted).
- out_pc  out  XLEN  pc of the head entry.
- out_instr  out  XLEN  head instruction word.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async, rst=1): rd_ptr=0, wr_ptr=0, count=0, all storage cleared to 0. Outputs while in reset: out_valid=0, in_ready=1, out_pc=0, out_instr=NOP_INSTR.
- Pointers are $clog2(DEPTH)+1 bits wide, with the MSB as the wrap bit.
  - empty = (rd_ptr == wr_ptr).
  - full = index bits equal and wrap bits differ.
  - Wrap-around happens naturally modulo 2*DEPTH.
- in_ready = ~full. It does not depend on out_ready, so there is no combinational path from the output side to the input side.
- push = in_valid & in_ready & ~flush. pop = out_valid & out_ready & ~flush.
- out_valid = ~empty.
  - When not empty, out_pc and out_instr are mem[rd_ptr] (combinational read of registered storage).
  - When empty, out_pc=0 and out_instr=NOP_INSTR.
- Latency: an entry pushed at edge N is visible on out_* after edge N. Minimum fetch-to-decode latency is one cycle, the same as the old latch.
- Simultaneous push and pop:
  - Both pointers advance and count is unchanged.
  - This is legal at any non-full, non-empty occupancy.
  - When full, push is blocked (in_ready=0), so only the pop occurs and count drops to DEPTH-1.
  - When empty, pop is impossible (out_valid=0), so only the push occurs.
- Flush (synchronous, flush=1 at an edge):
  - rd_ptr = wr_ptr = 0 and count = 0. Storage contents are don't-care.
  - Any in_valid or out_ready in the same cycle is ignored; nothing is written or consumed.
  - in_ready remains ~full during the flush cycle. The producer must treat the flush itself as the drop signal.
- Reset asserted mid-operation (including during flush or when full): immediate return to the reset state, no clock required.
- Data is never written while full and never read as valid while empty. Each entry carries pc and instr as one atomic pair.

Decomposition:
- Package fetch_pkg:
  - XLEN_DEFAULT=32.
  - NOP_INSTR constant 32'h0000_0013.
  - Typedef fetch_entry_t = struct {pc[XLEN-1:0], instr[XLEN-1:0]}, shared with the decode and redirect logic.
- One sub-module is natural: fetch_queue_mem.
  - DEPTH x 2*XLEN register array.
  - Synchronous write, asynchronous read, async reset clear.
  - Pointer, count and handshake logic stay in fetch_queue.

Test Plan:
1. Reset then idle.
   - Stimulus: rst pulse mid-cycle.
   - Required: out_valid=0, in_ready=1, count=0, out_instr=32'h0000_0013, out_pc=0 immediately, without a clock edge.
2. Fill and drain, DEPTH=4.
   - Fill: push pc 0x0,0x4,0x8,0xC with out_ready=0. Required: count=4, in_ready=0. A 5th push (pc 0x10) is not accepted.
   - Drain: then out_ready=1. Required: pops in order 0x0..0xC, then out_valid=0.
3. Streaming.
   - Stimulus: in_valid=1 and out_ready=1 continuously for 20 cycles, pc incrementing by 4 from 0x100.
   - Required: output is the same sequence delayed one cycle, count stays at 1, and the pointers wrap at least twice.
4. Full with simultaneous push and pop.
   - Stimulus: at count=4, in_valid=1 and out_ready=1.
   - Required: head popped, new entry not accepted, count=3. Next cycle the push is accepted and count=4.
5. Flush with pending traffic.
   - Stimulus: count=3, then flush=1 with in_valid=1 (pc 0x200) and out_ready=1.
   - Required: next cycle count=0, out_valid=0, and 0x200 is never output.
   - Follow-up: a push of 0x300 the cycle after appears as the head.
6. Reset mid-operation.
   - Stimulus: assert rst while count=2 and in_valid=1.
   - Required: immediate empty state. After release, the first push of 0x40 is output first with no stale entries.
